// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit that owns the HI/LO registers (shift-add multiply, restoring divide).
// Optional: define MULDIV_EARLY_TERM_EN to let multiplies leave CALC once the remaining multiplier is zero.

module muldiv_unit #(
  parameter int DATA_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [DATA_SIZE-1:0] a,
  input  logic [DATA_SIZE-1:0] b,
  input  logic                 mthi,
  input  logic                 mtlo,
  input  logic [DATA_SIZE-1:0] wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 div_zero,
  output logic [DATA_SIZE-1:0] hi,
  output logic [DATA_SIZE-1:0] lo
);

  // state | meaning
  // IDLE  | waiting for start; MTHI/MTLO honoured
  // CALC  | one multiply or divide step per cycle
  // FIX   | sign correction, HI/LO written
  // DONE  | done pulse; MTHI/MTLO and a new start honoured

  localparam int N  = DATA_SIZE;
  localparam int CW = $clog2(DATA_SIZE);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_SIZE - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           last_q, last_d;
  logic           div_q, div_d;
  logic           neg_res_q, neg_res_d;
  logic           neg_rem_q, neg_rem_d;
  logic           dz_q, dz_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mpl_q, mpl_d;
  logic [N-1:0]   hi_q, hi_d;
  logic [N-1:0]   lo_q, lo_d;

  logic           a_neg, b_neg;
  logic [N-1:0]   a_mag, b_mag;
  logic [2*N-1:0] mul_sum;
  logic [N-1:0]   mpl_rest;
  logic           mul_exit;
  logic [N:0]     rem_sh;
  logic           rem_ge;
  logic [N-1:0]   rem_new;
  logic [2*N-1:0] prod_fix;
  logic [N-1:0]   quo_fix, rem_fix;

  // Signed ops (op[0]==0) take magnitudes; most-negative maps to itself as an unsigned value.
  assign a_neg = ~op[0] & a[N-1];
  assign b_neg = ~op[0] & b[N-1];
  assign a_mag = a_neg ? (-a) : a;
  assign b_mag = b_neg ? (-b) : b;

  assign mul_sum  = acc_q + (mpl_q[0] ? mcand_q : {2*N{1'b0}});
  assign mpl_rest = mpl_q >> 1;

`ifdef MULDIV_EARLY_TERM_EN
  assign mul_exit = ~div_q & (mpl_rest == '0);
`else
  assign mul_exit = 1'b0;
`endif

  // Restoring divide: remainder in acc upper half, dividend/quotient in lower half.
  assign rem_sh  = {acc_q[2*N-1:N], acc_q[N-1]};
  assign rem_ge  = rem_sh >= {1'b0, mcand_q[N-1:0]};
  assign rem_new = rem_ge ? N'(rem_sh - {1'b0, mcand_q[N-1:0]}) : rem_sh[N-1:0];

  assign prod_fix = neg_res_q ? (-acc_q) : acc_q;
  assign quo_fix  = neg_res_q ? (-acc_q[N-1:0]) : acc_q[N-1:0];
  assign rem_fix  = neg_rem_q ? (-acc_q[2*N-1:N]) : acc_q[2*N-1:N];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mpl_d     = mpl_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (start) begin
          state_d   = S_CALC;
          div_d     = op[1];
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dz_d      = op[1] & (b == '0);
          cnt_d     = '0;
          last_d    = 1'b0;
          if (op[1]) begin
            acc_d   = {{N{1'b0}}, a_mag};
            mcand_d = {{N{1'b0}}, b_mag};
            mpl_d   = '0;
          end else begin
            acc_d   = '0;
            mcand_d = {{N{1'b0}}, a_mag};
            mpl_d   = b_mag;
          end
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      S_CALC: begin
        // Exit is taken from a registered flag so the step datapath and the state decode stay apart.
        if (last_q) begin
          state_d = S_FIX;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          last_d = (cnt_q == CNT_LAST) | mul_exit;
          if (!div_q) begin
            acc_d   = mul_sum;
            mcand_d = mcand_q << 1;
            mpl_d   = mpl_rest;
          end else begin
            acc_d   = {rem_new, acc_q[N-2:0], rem_ge};
          end
        end
      end
      S_FIX: begin
        state_d = S_DONE;
        if (!div_q) begin
          hi_d = prod_fix[2*N-1:N];
          lo_d = prod_fix[N-1:0];
        end else if (!dz_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mpl_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mpl_q     <= mpl_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy     = (state_q == S_CALC) | (state_q == S_FIX);
  assign done     = (state_q == S_DONE);
  assign div_zero = (state_q == S_DONE) & dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: fixed vectors, corner-case sequences and random ops
// against an arithmetic reference model. Honours MULDIV_EARLY_TERM_EN for expected latency.

module tb_muldiv_unit;
  localparam int N = 32;
`ifdef MULDIV_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, start, mthi, mtlo;
  logic [1:0]    op;
  logic [N-1:0]  a, b, wdata;
  logic          busy, done, div_zero;
  logic [N-1:0]  hi, lo;

  int checks   = 0;
  int failures = 0;
  logic [N-1:0] mdl_hi, mdl_lo;

  muldiv_unit #(.DATA_SIZE(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         dz;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Expected cycles from the start edge to the edge after which done is seen.
  function automatic int exp_lat(input logic [1:0] o, input logic [N-1:0] bb);
    int iters;
    logic [N-1:0] m;
    iters = N;
    m = (!o[0] && bb[N-1]) ? -bb : bb;
    if (EARLY && !o[1]) begin
      iters = 1;
      for (int i = 0; i < N; i++) if (m[i]) iters = i + 1;
    end
    return iters + 2;
  endfunction

  task automatic ref_op(input logic [1:0] o, input logic [N-1:0] aa, input logic [N-1:0] bb,
                        output logic [N-1:0] rh, output logic [N-1:0] rl, output logic dz);
    logic signed [63:0] sa, sb, sp;
    logic [63:0] ua, ub, up;
    sa = $signed({{32{aa[N-1]}}, aa});
    sb = $signed({{32{bb[N-1]}}, bb});
    ua = {32'b0, aa};
    ub = {32'b0, bb};
    dz = 1'b0;
    rh = mdl_hi;
    rl = mdl_lo;
    case (o)
      2'd0: begin sp = sa * sb; {rh, rl} = sp; end
      2'd1: begin up = ua * ub; {rh, rl} = up; end
      2'd2: if (bb == 0) dz = 1'b1;
            else begin sp = sa / sb; rl = sp[N-1:0]; sp = sa % sb; rh = sp[N-1:0]; end
      default: if (bb == 0) dz = 1'b1;
            else begin up = ua / ub; rl = up[N-1:0]; up = ua % ub; rh = up[N-1:0]; end
    endcase
    mdl_hi = rh;
    mdl_lo = rl;
  endtask

  // Presents start for exactly one edge, then scrambles op/a/b to show they were latched.
  task automatic launch(input logic [1:0] o, input logic [N-1:0] aa, input logic [N-1:0] bb);
    op = o; a = aa; b = bb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
    chk("busy_after_start", {63'b0, busy}, 64'd1);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
  endtask

  task automatic run_check(input string name, input logic [1:0] o,
                           input logic [N-1:0] aa, input logic [N-1:0] bb);
    int lat;
    logic [N-1:0] eh, el;
    logic edz;
    @(negedge clk);
    launch(o, aa, bb);
    wait_done(lat);
    ref_op(o, aa, bb, eh, el, edz);
    chk({name, "_lat"}, 64'(lat), 64'(exp_lat(o, bb)));
    chk({name, "_hi"}, {32'b0, hi}, {32'b0, eh});
    chk({name, "_lo"}, {32'b0, lo}, {32'b0, el});
    chk({name, "_dz"}, {63'b0, div_zero}, {63'b0, edz});
  endtask

  task automatic mt_write(input logic wh, input logic wl, input logic [N-1:0] d);
    @(negedge clk);
    mthi = wh; mtlo = wl; wdata = d;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    if (wh) mdl_hi = d;
    if (wl) mdl_lo = d;
    chk("mt_hi", {32'b0, hi}, {32'b0, mdl_hi});
    chk("mt_lo", {32'b0, lo}, {32'b0, mdl_lo});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int lat, sel;
    logic [N-1:0] eh, el, aa, bb;
    logic edz, saw_done, saw_busy;
    logic [1:0] o;

    vecs[0] = '{2'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2] = '{2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[4] = '{2'd1, 32'd9,        32'd3,        32'h00000000, 32'd27,       1'b0};
    vecs[5] = '{2'd3, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[6] = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[7] = '{2'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};

    rst_n = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'd0; a = '0; b = '0; wdata = '0;
    mdl_hi = '0; mdl_lo = '0;
    #12;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_dz", {63'b0, div_zero}, 64'd0);
    chk("rst_hi", {32'b0, hi}, 64'd0);
    chk("rst_lo", {32'b0, lo}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(lat);
      ref_op(vecs[i].op, vecs[i].a, vecs[i].b, eh, el, edz);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(exp_lat(vecs[i].op, vecs[i].b)));
      chk($sformatf("vec%0d_hi", i), {32'b0, hi}, {32'b0, vecs[i].hi});
      chk($sformatf("vec%0d_lo", i), {32'b0, lo}, {32'b0, vecs[i].lo});
      chk($sformatf("vec%0d_dz", i), {63'b0, div_zero}, {63'b0, vecs[i].dz});
    end

    // Back-to-back: second start presented during the done cycle.
    run_check("b2b_first", 2'd1, 32'd6, 32'd7);
    launch(2'd3, 32'd50, 32'd7);
    chk("b2b_done_low", {63'b0, done}, 64'd0);
    wait_done(lat);
    ref_op(2'd3, 32'd50, 32'd7, eh, el, edz);
    chk("b2b_lat", 64'(lat), 64'(exp_lat(2'd3, 32'd7)));
    chk("b2b_hi", {32'b0, hi}, 64'd1);
    chk("b2b_lo", {32'b0, lo}, 64'd7);

    // start held high mid-operation must not launch anything.
    @(negedge clk);
    launch(2'd0, 32'hFFFFFFFB, 32'h40000000);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'd3; a = 32'd1000; b = 32'd10;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    ref_op(2'd0, 32'hFFFFFFFB, 32'h40000000, eh, el, edz);
    chk("busy_start_lat", 64'(lat + 7), 64'(exp_lat(2'd0, 32'h40000000)));
    chk("busy_start_hi", {32'b0, hi}, 64'hFFFFFFFE);
    chk("busy_start_lo", {32'b0, lo}, 64'hC0000000);
    @(posedge clk); #1;
    chk("busy_start_idle", {62'b0, busy, done}, 64'd0);

    // Divide by zero with preloaded HI/LO; MTHI/MTLO with start and during CALC are dropped.
    mt_write(1'b1, 1'b1, 32'h33);
    mt_write(1'b1, 1'b0, 32'h11);
    mt_write(1'b0, 1'b1, 32'h22);
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hAB;
    launch(2'd3, 32'd5, 32'd0);
    repeat (3) @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    wait_done(lat);
    chk("dz_lat", 64'(lat + 2), 64'(exp_lat(2'd3, 32'd0)));
    chk("dz_flag", {63'b0, div_zero}, 64'd1);
    chk("dz_hi", {32'b0, hi}, 64'h11);
    chk("dz_lo", {32'b0, lo}, 64'h22);
    @(posedge clk); #1;
    chk("dz_flag_drop", {63'b0, div_zero}, 64'd0);

    // Reset during iteration 10 of a MULTU.
    @(negedge clk);
    launch(2'd1, 32'h12345678, 32'h9ABCDEF0);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    mdl_hi = '0; mdl_lo = '0;
    chk("rstmid_busy", {63'b0, busy}, 64'd0);
    chk("rstmid_done", {63'b0, done}, 64'd0);
    chk("rstmid_hi", {32'b0, hi}, 64'd0);
    chk("rstmid_lo", {32'b0, lo}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    saw_done = 1'b0; saw_busy = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      saw_done |= done;
      saw_busy |= busy;
    end
    chk("rstmid_no_done", {62'b0, saw_busy, saw_done}, 64'd0);

    // Random operations against the model, with occasional idle MTHI/MTLO.
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      sel = $urandom_range(0, 3);
      case (sel)
        0: aa = $urandom;
        1: aa = 32'($urandom_range(0, 255));
        2: aa = 32'h80000000;
        default: aa = -32'($urandom_range(1, 1000));
      endcase
      sel = $urandom_range(0, 5);
      case (sel)
        0: bb = 32'd0;
        1: bb = 32'hFFFFFFFF;
        2: bb = 32'($urandom_range(1, 63));
        3: bb = -32'($urandom_range(1, 63));
        default: bb = $urandom;
      endcase
      if ($urandom_range(0, 4) == 0) mt_write(1'($urandom), 1'($urandom), $urandom);
      run_check($sformatf("rnd%0d", i), o, aa, bb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
